// File: rtl/barrel_shift_pipe.sv
`timescale 1ns/1ps
// barrel_shift_pipe
// Pipelined left/right barrel shifter with logical, arithmetic and rotate modes,
// wrapped in a valid/ready stream interface.
//
// The shift is split into num_levels = clog2(width) mux levels. Level j moves the
// word by 2^j when shift[j] is set. Each pipeline stage applies levelsPerStage
// levels and registers the result, giving num_stages = ceil(num_levels/levelsPerStage)
// cycles of latency. All stages advance together; bubbles are not collapsed.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   iBits, shift,     input word, shift amount, direction (0 = left, 1 = right),
//   dir, mode         mode (0 logical, 1 arithmetic, 2 rotate, 3 as logical)
//   iValid / iReady   input handshake (iReady is combinational from oReady)
//   oBits / oValid    registered result and its valid flag
//   oReady            consumer accepts the result
//   inFlight          number of valid items currently held in the pipeline
module barrel_shift_pipe #(
  parameter int width          = 8,
  parameter int levelsPerStage = 1,
  localparam int num_levels    = $clog2(width),
  localparam int num_stages    = (num_levels + levelsPerStage - 1) / levelsPerStage,
  localparam int count_w       = $clog2(num_stages + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [width-1:0]      iBits,
  input  logic [num_levels-1:0] shift,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  iValid,
  output logic                  iReady,
  output logic [width-1:0]      oBits,
  output logic                  oValid,
  input  logic                  oReady,
  output logic [count_w-1:0]    inFlight
);

  // The last stage's control fields are never needed, so control registers exist
  // only between stages. Keep at least one entry so the arrays stay legal.
  localparam int ctl_n = (num_stages > 1) ? num_stages - 1 : 1;

  // Applies mux levels lo..hi-1 of the shift to x.
  function automatic logic [width-1:0] apply_levels(
    input logic [width-1:0]      x,
    input logic [num_levels-1:0] amt,
    input logic                  right,
    input logic [1:0]            md,
    input int                    lo,
    input int                    hi
  );
    logic [width-1:0] y;
    y = x;
    for (int j = 0; j < num_levels; j++) begin
      if (j >= lo && j < hi && amt[j]) begin
        case (md)
          2'd2: y = right ? ((y >> (1 << j)) | (y << (width - (1 << j))))
                          : ((y << (1 << j)) | (y >> (width - (1 << j))));
          // Right arithmetic: the MSB is still the original sign bit because
          // every earlier level preserved it.
          2'd1: y = right ? ((y >> (1 << j)) | (y[width-1] ? ~({width{1'b1}} >> (1 << j)) : '0))
                          : (y << (1 << j));
          default: y = right ? (y >> (1 << j)) : (y << (1 << j));
        endcase
      end
    end
    return y;
  endfunction

  // Per-stage inputs (stage 0 from the ports, others from the previous stage).
  logic [width-1:0]      src_data  [num_stages];
  logic [num_levels-1:0] src_shift [num_stages];
  logic                  src_dir   [num_stages];
  logic [1:0]            src_mode  [num_stages];
  logic                  src_valid [num_stages];
  logic [width-1:0]      stage_next[num_stages];

  // Pipeline registers.
  logic [width-1:0]      data_reg  [num_stages];
  logic                  valid_reg [num_stages];
  logic [num_levels-1:0] shift_reg [ctl_n];
  logic                  dir_reg   [ctl_n];
  logic [1:0]            mode_reg  [ctl_n];
  logic [count_w-1:0]    in_flight_reg;

  logic adv;
  logic accept;
  logic leave;

  assign oValid   = valid_reg[num_stages-1];
  assign oBits    = data_reg[num_stages-1];
  assign inFlight = in_flight_reg;
  // The whole pipeline stalls only when the output is full and not taken.
  assign adv      = !(oValid && !oReady);
  assign iReady   = adv;
  assign accept   = iValid && adv;
  assign leave    = oValid && oReady;

  for (genvar gi = 0; gi < num_stages; gi++) begin : g_stage
    localparam int lo = gi * levelsPerStage;
    localparam int hi = (lo + levelsPerStage > num_levels) ? num_levels : lo + levelsPerStage;

    if (gi == 0) begin : g_first
      assign src_data[gi]  = iBits;
      assign src_shift[gi] = shift;
      assign src_dir[gi]   = dir;
      assign src_mode[gi]  = mode;
      assign src_valid[gi] = iValid;
    end else begin : g_next
      assign src_data[gi]  = data_reg[gi-1];
      assign src_shift[gi] = shift_reg[gi-1];
      assign src_dir[gi]   = dir_reg[gi-1];
      assign src_mode[gi]  = mode_reg[gi-1];
      assign src_valid[gi] = valid_reg[gi-1];
    end

    assign stage_next[gi] = apply_levels(src_data[gi], src_shift[gi], src_dir[gi],
                                         src_mode[gi], lo, hi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < num_stages; k++) begin
        valid_reg[k] <= 1'b0;
        data_reg[k]  <= '0;
      end
      for (int k = 0; k < ctl_n; k++) begin
        shift_reg[k] <= '0;
        dir_reg[k]   <= 1'b0;
        mode_reg[k]  <= 2'd0;
      end
      in_flight_reg <= '0;
    end else begin
      if (adv) begin
        for (int k = 0; k < num_stages; k++) begin
          valid_reg[k] <= src_valid[k];
          data_reg[k]  <= stage_next[k];
        end
        for (int k = 0; k < num_stages - 1; k++) begin
          shift_reg[k] <= src_shift[k];
          dir_reg[k]   <= src_dir[k];
          mode_reg[k]  <= src_mode[k];
        end
      end
      case ({accept, leave})
        2'b10:   in_flight_reg <= in_flight_reg + 1'b1;
        2'b01:   in_flight_reg <= in_flight_reg - 1'b1;
        default: in_flight_reg <= in_flight_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
`timescale 1ns/1ps
// Testbench for barrel_shift_pipe: an 8-bit, one-level-per-stage instance for
// directed scenarios and a 32-bit, two-levels-per-stage instance for a random
// stream against a word-level reference model.
module tb_barrel_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0]  a_bits, a_obits;
  logic [2:0]  a_shift;
  logic        a_dir, a_ivalid, a_iready, a_ovalid, a_oready;
  logic [1:0]  a_mode;
  logic [2:0]  a_inflight;

  logic [31:0] b_bits, b_obits;
  logic [4:0]  b_shift;
  logic        b_dir, b_ivalid, b_iready, b_ovalid, b_oready;
  logic [1:0]  b_mode;
  logic [2:0]  b_inflight;

  barrel_shift_pipe #(.width(8), .levelsPerStage(1)) dut8 (
    .clk(clk), .rst(rst), .iBits(a_bits), .shift(a_shift), .dir(a_dir), .mode(a_mode),
    .iValid(a_ivalid), .iReady(a_iready), .oBits(a_obits), .oValid(a_ovalid),
    .oReady(a_oready), .inFlight(a_inflight)
  );

  barrel_shift_pipe #(.width(32), .levelsPerStage(2)) dut32 (
    .clk(clk), .rst(rst), .iBits(b_bits), .shift(b_shift), .dir(b_dir), .mode(b_mode),
    .iValid(b_ivalid), .iReady(b_iready), .oBits(b_obits), .oValid(b_ovalid),
    .oReady(b_oready), .inFlight(b_inflight)
  );

  int vectors = 0;
  int miscompares = 0;

  // Word-level reference: whole shift at once on a 64-bit scratch value.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s,
                                            input logic d, input logic [1:0] m, input int w);
    logic [63:0] mask, v, r;
    mask = (64'd1 << w) - 64'd1;
    v = {32'd0, x} & mask;
    if (s == 0) return v[31:0];
    if (m == 2'd2)
      r = d ? ((v >> s) | (v << (w - s))) : ((v << s) | (v >> (w - s)));
    else if (!d)
      r = v << s;
    else begin
      r = v >> s;
      if (m == 2'd1 && v[w-1]) r = r | (mask & ~(mask >> s));
    end
    r = r & mask;
    return r[31:0];
  endfunction

  // Presents one item to the 8-bit instance and waits for the first oValid.
  // lat counts negedges after the accepting edge (1 = result after that edge).
  task automatic send_wait8(input logic [7:0] x, input logic [2:0] s, input logic d,
                            input logic [1:0] m, output logic [7:0] res,
                            output int lat, output int maxif);
    @(negedge clk);
    a_bits = x; a_shift = s; a_dir = d; a_mode = m; a_ivalid = 1'b1; a_oready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_ivalid = 1'b0;
    lat = 1;
    maxif = a_inflight;
    while (!a_ovalid && lat < 20) begin
      @(negedge clk);
      lat++;
      if (int'(a_inflight) > maxif) maxif = a_inflight;
    end
    res = a_obits;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_bits = 8'h5A; a_shift = 3'd1; a_dir = 1'b0; a_mode = 2'd0; a_ivalid = 1'b1; a_oready = 1'b1;
    b_bits = 32'h1234_5678; b_shift = 5'd4; b_dir = 1'b1; b_mode = 2'd1; b_ivalid = 1'b1; b_oready = 1'b1;
    // iValid is high across an edge while in reset: nothing may be captured.
    @(negedge clk); #1;
    vectors++;
    if (a_ovalid !== 1'b0 || a_inflight !== 3'd0 || a_obits !== 8'h00) begin
      miscompares++;
      $display("FAIL reset8: got oValid=%b inFlight=%0d oBits=%h, want 0 0 00", a_ovalid, a_inflight, a_obits);
    end
    vectors++;
    if (b_ovalid !== 1'b0 || b_inflight !== 3'd0 || b_obits !== 32'd0) begin
      miscompares++;
      $display("FAIL reset32: got oValid=%b inFlight=%0d oBits=%h, want 0 0 0", b_ovalid, b_inflight, b_obits);
    end
    vectors++;
    if (a_iready !== 1'b1 || b_iready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_iready: got %b/%b, want 1/1", a_iready, b_iready);
    end
    a_ivalid = 1'b0; b_ivalid = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (a_ovalid !== 1'b0 || a_inflight !== 3'd0 || b_ovalid !== 1'b0 || b_inflight !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: got oValid=%b/%b inFlight=%0d/%0d, want 0", a_ovalid, b_ovalid, a_inflight, b_inflight);
    end
  endtask

  task automatic test_latency();
    logic [7:0] res;
    int lat, maxif;
    send_wait8(8'h91, 3'd3, 1'b0, 2'd0, res, lat, maxif);
    vectors++;
    if (lat !== 3) begin
      miscompares++;
      $display("FAIL latency: got %0d cycles, want 3", lat);
    end
    vectors++;
    if (res !== 8'h88) begin
      miscompares++;
      $display("FAIL latency_data: got %h, want 88", res);
    end
    vectors++;
    if (maxif !== 1) begin
      miscompares++;
      $display("FAIL latency_inflight: got peak %0d, want 1", maxif);
    end
    @(negedge clk); #1;
    vectors++;
    if (a_inflight !== 3'd0 || a_ovalid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_drain: got inFlight=%0d oValid=%b, want 0 0", a_inflight, a_ovalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[2];
    int cyc[2];
    int seen = 0;
    @(negedge clk);
    a_bits = 8'h91; a_shift = 3'd2; a_dir = 1'b1; a_mode = 2'd1; a_ivalid = 1'b1; a_oready = 1'b1;
    @(negedge clk);
    a_mode = 2'd0;
    @(negedge clk);
    a_ivalid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (a_ovalid && seen < 2) begin
        got[seen] = a_obits;
        cyc[seen] = c;
        seen++;
      end
    end
    vectors++;
    if (seen !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, want 2", seen);
    end else begin
      vectors++;
      if (got[0] !== 8'hE4 || got[1] !== 8'h24) begin
        miscompares++;
        $display("FAIL b2b_data: got %h %h, want e4 24", got[0], got[1]);
      end
      vectors++;
      if (cyc[1] !== cyc[0] + 1) begin
        miscompares++;
        $display("FAIL b2b_spacing: got cycles %0d %0d, want consecutive", cyc[0], cyc[1]);
      end
    end
  endtask

  task automatic test_rotate();
    logic [2:0] ts[8] = '{3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       td[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] tm[8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [7:0] tw[8] = '{8'h8C, 8'hC8, 8'h91, 8'h91, 8'h91, 8'h91, 8'h91, 8'h91};
    logic [7:0] res;
    int lat, maxif;
    for (int i = 0; i < 8; i++) begin
      send_wait8(8'h91, ts[i], td[i], tm[i], res, lat, maxif);
      vectors++;
      if (res !== tw[i] || lat !== 3) begin
        miscompares++;
        $display("FAIL rotate_%0d (s=%0d d=%0d m=%0d): got %h lat %0d, want %h lat 3",
                 i, ts[i], td[i], tm[i], res, lat, tw[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] ib[4];
    logic [2:0] is[4];
    logic       id[4];
    logic [1:0] im[4];
    logic [7:0] q[$];
    logic [7:0] held, e;
    logic [31:0] t;
    int sent = 0, got = 0, stall_left = 0, maxif = 0;
    bit stalled_once = 0;
    for (int i = 0; i < 4; i++) begin
      ib[i] = 8'($urandom); is[i] = 3'($urandom); id[i] = 1'($urandom); im[i] = 2'($urandom);
    end
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (a_ovalid && !stalled_once) begin
        stalled_once = 1;
        stall_left = 2;
        held = a_obits;
      end
      a_oready = (stall_left == 0);
      a_ivalid = (sent < 4);
      if (sent < 4) begin
        a_bits = ib[sent]; a_shift = is[sent]; a_dir = id[sent]; a_mode = im[sent];
      end
      #1;
      vectors++;
      if (int'(a_inflight) !== q.size()) begin
        miscompares++;
        $display("FAIL bp_inflight: got %0d, want %0d", a_inflight, q.size());
      end
      if (int'(a_inflight) > maxif) maxif = a_inflight;
      if (stall_left > 0) begin
        vectors++;
        if (a_iready !== 1'b0 || a_ovalid !== 1'b1 || a_obits !== held) begin
          miscompares++;
          $display("FAIL bp_stall: got iReady=%b oValid=%b oBits=%h, want 0 1 %h", a_iready, a_ovalid, a_obits, held);
        end
      end
      if (a_ivalid && a_iready) begin
        t = ref_shift({24'd0, ib[sent]}, int'(is[sent]), id[sent], im[sent], 8);
        q.push_back(t[7:0]);
        sent++;
      end
      if (a_ovalid && a_oready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_spurious: got oBits=%h, want no output", a_obits);
        end else begin
          e = q.pop_front();
          if (a_obits !== e) begin
            miscompares++;
            $display("FAIL bp_order_%0d: got %h, want %h", got, a_obits, e);
          end
        end
        got++;
      end
      if (stall_left > 0) stall_left--;
    end
    a_ivalid = 1'b0; a_oready = 1'b1;
    vectors++;
    if (got !== 4 || !stalled_once || maxif > 3) begin
      miscompares++;
      $display("FAIL bp_summary: got %0d results stalled=%0d peak=%0d, want 4 1 <=3", got, stalled_once, maxif);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res, x;
    logic [31:0] t;
    int lat, maxif;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_bits = 8'($urandom); a_shift = 3'($urandom); a_dir = 1'($urandom); a_mode = 2'($urandom);
      a_ivalid = 1'b1; a_oready = 1'b1;
    end
    @(negedge clk);
    a_ivalid = 1'b0; a_oready = 1'b0;
    #1;
    vectors++;
    if (a_inflight !== 3'd3 || a_ovalid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_fill: got inFlight=%0d oValid=%b, want 3 1", a_inflight, a_ovalid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (a_ovalid !== 1'b0 || a_obits !== 8'h00 || a_inflight !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_clear: got oValid=%b oBits=%h inFlight=%0d, want 0 00 0", a_ovalid, a_obits, a_inflight);
    end
    @(negedge clk);
    rst = 1'b0; a_oready = 1'b1;
    x = 8'($urandom);
    send_wait8(x, 3'd5, 1'b1, 2'd1, res, lat, maxif);
    t = ref_shift({24'd0, x}, 5, 1'b1, 2'd1, 8);
    vectors++;
    if (lat !== 3 || res !== t[7:0]) begin
      miscompares++;
      $display("FAIL midrst_next: got %h lat %0d, want %h lat 3", res, lat, t[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_random32();
    logic [31:0] q[$];
    logic [31:0] e;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      b_ivalid = ($urandom % 4) != 0;
      b_bits = $urandom; b_shift = 5'($urandom); b_dir = 1'($urandom); b_mode = 2'($urandom);
      b_oready = ($urandom % 3) != 0;
      #1;
      vectors++;
      if (int'(b_inflight) !== q.size() || b_iready !== !(b_ovalid && !b_oready)) begin
        miscompares++;
        $display("FAIL rnd_ctrl c%0d: got inFlight=%0d iReady=%b, want %0d %b",
                 c, b_inflight, b_iready, q.size(), !(b_ovalid && !b_oready));
      end
      if (b_ivalid && b_iready) q.push_back(ref_shift(b_bits, int'(b_shift), b_dir, b_mode, 32));
      if (b_ovalid && b_oready) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious c%0d: got %h, want no output", c, b_obits);
        end else begin
          e = q.pop_front();
          if (b_obits !== e) begin
            miscompares++;
            $display("FAIL rnd_data c%0d: got %h, want %h", c, b_obits, e);
          end
        end
      end
    end
    b_ivalid = 1'b0; b_oready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk); #1;
      if (b_ovalid) begin
        e = q.pop_front();
        vectors++;
        if (b_obits !== e) begin
          miscompares++;
          $display("FAIL rnd_drain: got %h, want %h", b_obits, e);
        end
      end
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rnd_left: got %0d results missing, want 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_rotate();
    test_backpressure();
    test_reset_mid();
    test_random32();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
